// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared width, op codes and controller states for alu_op_sequencer
package alu_seq_pkg;
    localparam int WIDTH = 32;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;
    typedef enum logic [1:0] {IDLE, EXEC, INV, SHIFT} state_t;
endpackage

// File: rtl/alu_seq_datapath.sv
// alu_seq_datapath: combinational bitwise units, adder with carry-in and one-bit shift step
module alu_seq_datapath #(
    parameter int WIDTH = alu_seq_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             left,
    output logic [WIDTH-1:0] and_y,
    output logic [WIDTH-1:0] or_y,
    output logic [WIDTH-1:0] xor_y,
    output logic [WIDTH-1:0] not_a,
    output logic [WIDTH-1:0] not_b,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] step,
    output logic             ovf
);
    assign and_y = a & b;
    assign or_y  = a | b;
    assign xor_y = a ^ b;
    notgate32bit u_not_a (.a(a), .y(not_a));
    notgate32bit u_not_b (.a(b), .y(not_b));
    assign sum  = a + b + {{(WIDTH-1){1'b0}}, cin};
    // b here is the adder's actual B input, already inverted for SUB
    assign ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign step = left ? {a[WIDTH-2:0], 1'b0} : {1'b0, a[WIDTH-1:1]};
endmodule

// File: rtl/notgate32bit.sv
// notgate32bit: structural 32-bit bitwise inverter
module notgate32bit (
    input  logic [31:0] a,
    output logic [31:0] y
);
    assign y = ~a;
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle ALU controller with start/done handshake
module alu_op_sequencer #(
    parameter int WIDTH = alu_seq_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);
    import alu_seq_pkg::*;
    state_t state, state_n;
    logic [2:0] op_r, op_n;
    logic [WIDTH-1:0] a_r, a_n, b_r, b_n, result_n;
    logic [4:0] cnt, cnt_n;
    logic cin, cin_n, done_n, zero_n, ovf_n;
    logic [WIDTH-1:0] and_y, or_y, xor_y, not_a, not_b, sum, step, alu_y, shift_y;
    logic dp_ovf, arith;
    alu_seq_datapath #(.WIDTH(WIDTH)) u_dp (
        .a(a_r), .b(b_r), .cin(cin), .left(op_r == OP_SLL),
        .and_y(and_y), .or_y(or_y), .xor_y(xor_y), .not_a(not_a), .not_b(not_b),
        .sum(sum), .step(step), .ovf(dp_ovf)
    );
    assign alu_y = (op_r == OP_AND) ? and_y :
                   (op_r == OP_OR)  ? or_y  :
                   (op_r == OP_XOR) ? xor_y :
                   (op_r == OP_NOT) ? not_a : sum;
    assign arith = (op_r == OP_ADD) || (op_r == OP_SUB);
    // a_r doubles as the shift working register; count 0 passes A through
    assign shift_y = (cnt == 5'd0) ? a_r : step;
    assign busy = state != IDLE;
    always_comb begin
        state_n  = state;
        op_n     = op_r;
        a_n      = a_r;
        b_n      = b_r;
        cin_n    = cin;
        cnt_n    = cnt;
        result_n = result;
        zero_n   = zero;
        ovf_n    = overflow;
        done_n   = 1'b0;
        case (state)
            IDLE: if (start) begin
                op_n    = op;
                a_n     = a;
                b_n     = b;
                cin_n   = 1'b0;
                cnt_n   = b[4:0];
                state_n = (op == OP_SUB) ? INV : (op == OP_SLL || op == OP_SRL) ? SHIFT : EXEC;
            end
            INV: begin
                b_n     = not_b;
                cin_n   = 1'b1;
                state_n = EXEC;
            end
            EXEC: begin
                result_n = alu_y;
                zero_n   = alu_y == '0;
                ovf_n    = arith && dp_ovf;
                done_n   = 1'b1;
                state_n  = IDLE;
            end
            SHIFT: if (cnt <= 5'd1) begin
                result_n = shift_y;
                zero_n   = shift_y == '0;
                ovf_n    = 1'b0;
                done_n   = 1'b1;
                state_n  = IDLE;
            end else begin
                a_n   = step;
                cnt_n = cnt - 5'd1;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_r     <= '0;
            a_r      <= '0;
            b_r      <= '0;
            cin      <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            op_r     <= op_n;
            a_r      <= a_n;
            b_r      <= b_n;
            cin      <= cin_n;
            cnt      <= cnt_n;
            result   <= result_n;
            zero     <= zero_n;
            overflow <= ovf_n;
            done     <= done_n;
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and randomized checks against an arithmetic reference model
module tb_alu_op_sequencer;
    logic clk = 1'b0;
    logic rst_n, start, busy, done, zero, overflow;
    logic [2:0] op;
    logic [31:0] a, b, result;
    int checks = 0;
    int failures = 0;
    logic [31:0] last_res;

    alu_op_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .zero(zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic v, output int k);
        longint s;
        int n;
        n = int'(y[4:0]);
        v = 1'b0;
        k = 1;
        s = 0;
        case (o)
            3'd0: begin r = x + y; s = longint'($signed(x)) + longint'($signed(y)); v = s != longint'($signed(r)); end
            3'd1: begin r = x - y; s = longint'($signed(x)) - longint'($signed(y)); v = s != longint'($signed(r)); k = 2; end
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = x ^ y;
            3'd5: r = ~x;
            3'd6: begin r = x << n; k = (n == 0) ? 1 : n; end
            default: begin r = x >> n; k = (n == 0) ? 1 : n; end
        endcase
    endtask

    // called at a negedge with the DUT idle (or pulsing done); returns at the done negedge
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input bit inject);
        logic [31:0] er;
        logic ev;
        int ek, lat, bc;
        model(o, x, y, er, ev, ek);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        lat = 0;
        bc = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (done) break;
            bc += int'(busy);
            start = inject && lat == 3;
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(lat - 1), 32'(ek));
        check({tag, "_busy_cycles"}, 32'(bc), 32'(ek));
        check({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
        check({tag, "_result"}, result, er);
        check({tag, "_zero"}, {31'b0, zero}, {31'b0, er == 32'd0});
        check({tag, "_overflow"}, {31'b0, overflow}, {31'b0, ev});
        last_res = er;
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
        check({tag, "_held"}, result, last_res);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; last_res = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'b0, zero}, 32'd0);
        check("rst_overflow", {31'b0, overflow}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("add", 3'd0, 32'd5, 32'd7, 1'b0);
        idle_check("add");
        run_op("sub", 3'd1, 32'd3, 32'd5, 1'b0);
        idle_check("sub");
        run_op("sub_ovf", 3'd1, 32'h8000_0000, 32'd1, 1'b0);
        run_op("add_ovf", 3'd0, 32'h7FFF_FFFF, 32'd1, 1'b0);
        run_op("xor_zero", 3'd4, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        run_op("not", 3'd5, 32'h0F0F_1234, 32'd0, 1'b0);
        run_op("sll31", 3'd6, 32'd1, 32'd31, 1'b0);
        run_op("srl0", 3'd7, 32'hA5A5_0001, 32'h0000_0FE0, 1'b0);
        idle_check("srl0");
        run_op("srl_inject", 3'd7, 32'hF000_0000, 32'd20, 1'b1);
        idle_check("srl_inject");
        run_op("b2b_first", 3'd6, 32'h0000_00FF, 32'd4, 1'b0);
        run_op("b2b_second", 3'd1, 32'd100, 32'd1, 1'b0);
        idle_check("b2b");
        start = 1'b1; op = 3'd6; a = 32'd1; b = 32'd31;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_shift_busy", {31'b0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", {31'b0, busy}, 32'd0);
        check("async_rst_done", {31'b0, done}, 32'd0);
        check("async_rst_result", result, 32'd0);
        check("async_rst_zero", {31'b0, zero}, 32'd0);
        check("async_rst_overflow", {31'b0, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("post_rst_add", 3'd0, 32'd40, 32'd2, 1'b0);
        for (int i = 0; i < 150; i++) begin
            logic [2:0] ro;
            logic [31:0] rx, ry;
            ro = 3'($urandom);
            rx = $urandom;
            ry = ($urandom_range(3, 0) == 0) ? rx : $urandom;
            run_op("rand", ro, rx, ry, 1'b0);
            if ($urandom_range(1, 0) == 1) idle_check("rand_idle");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
